gate_tt_sequencer: RTL and testbench

GATE_TT_SEQUENCER -- requirements
Module: gate_tt_sequencer

---
 rtl/gate_tt_pkg.sv | 31 +++
 rtl/gate_tt_sequencer_if.sv | 25 ++
 rtl/gate_ref_model.sv | 13 +
 rtl/gate_tt_sequencer.sv | 119 +++++++++++
 tb/tb_gate_tt_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gate_tt_pkg.sv
// Shared types and the reference truth function for the two-input gate sequencer.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpAnd  = 2'b00,
        OpOr   = 2'b01,
        OpXor  = 2'b10,
        OpNand = 2'b11
    } op_e;

    function automatic logic expected_y(op_e op, logic a, logic b);
        logic r;
        r = 1'b0;
        case (op)
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpXor:   r = a ^ b;
            OpNand:  r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Control/result bundle between the sweep controller side and the sequencer.
interface gate_tt_sequencer_if;

    logic       start;
    logic [1:0] op_sel;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    modport master (
        output start, op_sel, y,
        input  a, b, busy, done, pass, err_count, fail_mask
    );

    modport slave (
        input  start, op_sel, y,
        output a, b, busy, done, pass, err_count, fail_mask
    );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational expected output of the selected two-input function.
module gate_ref_model
    import gate_tt_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    output logic y_exp
);

    assign y_exp = expected_y(op, a, b);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps a two-input gate through 00,01,10,11, holding each vector HOLD_CYCLES
// cycles, and checks its output against the latched expected function.
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    gate_tt_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0] HoldReload = CntW'(HOLD_CYCLES - 1);

    state_e          state_q;
    op_e             op_q;
    logic [1:0]      idx_q;
    logic [CntW-1:0] hold_q;
    logic            a_q;
    logic            b_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [2:0]      err_q;
    logic [3:0]      mask_q;

    logic            y_exp;
    logic            mismatch;
    logic [2:0]      err_next;
    logic [1:0]      idx_next;

    gate_ref_model u_ref (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y_exp (y_exp)
    );

    always_comb begin
        mismatch = (bus.y != y_exp);
        err_next = err_q + {2'b00, mismatch};
        idx_next = idx_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpAnd;
            idx_q   <= 2'd0;
            hold_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        op_q    <= op_e'(bus.op_sel);
                        idx_q   <= 2'd0;
                        hold_q  <= HoldReload;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= 3'd0;
                        mask_q  <= 4'd0;
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    if (hold_q == '0) begin
                        state_q <= StCheck;
                    end else begin
                        hold_q <= hold_q - CntW'(1);
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_q         <= err_next;
                        mask_q[idx_q] <= 1'b1;
                    end
                    if (idx_q == 2'd3) begin
                        // pass must see this cycle's mismatch, so it uses err_next
                        pass_q  <= (err_next == 3'd0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_next;
                        a_q     <= idx_next[1];
                        b_q     <= idx_next[0];
                        hold_q  <= HoldReload;
                        state_q <= StDrive;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_mask = mask_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench: two sequencer instances (hold 4 and hold 1) driving a
// truth-table gate model, checked against a per-sweep expected timeline.
module tb_gate_tt_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_drv;
    logic [1:0] op_drv;
    logic [3:0] gut;
    logic       sel1;
    int         checks;
    int         failures;

    gate_tt_sequencer_if bus4 ();
    gate_tt_sequencer_if bus1 ();

    gate_tt_sequencer #(.HOLD_CYCLES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    gate_tt_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Gate under test: truth table indexed by {a,b}
    assign bus4.y      = gut[{bus4.a, bus4.b}];
    assign bus1.y      = gut[{bus1.a, bus1.b}];
    assign bus4.start  = start_drv & ~sel1;
    assign bus1.start  = start_drv & sel1;
    assign bus4.op_sel = op_drv;
    assign bus1.op_sel = op_drv;

    logic [3:0] obs_ctl;
    logic [7:0] obs_res;
    assign obs_ctl = sel1 ? {bus1.busy, bus1.done, bus1.a, bus1.b}
                          : {bus4.busy, bus4.done, bus4.a, bus4.b};
    assign obs_res = sel1 ? {bus1.pass, bus1.err_count, bus1.fail_mask}
                          : {bus4.pass, bus4.err_count, bus4.fail_mask};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] TtAnd = 4'b1000;

    function automatic logic [3:0] op_tt(input logic [1:0] op);
        case (op)
            2'b00:   return 4'b1000;
            2'b01:   return 4'b1110;
            2'b10:   return 4'b0110;
            default: return 4'b0111;
        endcase
    endfunction

    // One full sweep checked cycle by cycle; start re-pulsed at n==poke_a/poke_b.
    task automatic run_sweep(input logic [1:0] op, input logic [3:0] gtt,
                             input int poke_a, input int poke_b);
        int         h;
        int         len;
        logic [3:0] exp_mask;
        logic [2:0] exp_err;
        logic       exp_pass;
        logic [3:0] exp_ctl;
        logic [7:0] exp_res;
        h        = sel1 ? 1 : 4;
        len      = 4 * (h + 1);
        exp_mask = op_tt(op) ^ gtt;
        exp_err  = 3'($countones(exp_mask));
        exp_pass = (exp_mask == 4'd0);
        gut       = gtt;
        op_drv    = op;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        for (int n = 0; n <= len + 3; n++) begin
            if (n < len) exp_ctl = {2'b10, 2'(n / (h + 1))};
            else if (n == len) exp_ctl = 4'b0100;
            else exp_ctl = 4'b0000;
            checks++;
            if (obs_ctl !== exp_ctl) begin
                failures++;
                $display("FAIL ctl h=%0d op=%0d n=%0d got busy,done,a,b=%b want %b",
                         h, op, n, obs_ctl, exp_ctl);
            end
            if (n == 0 || n >= len) begin
                exp_res = (n == 0) ? 8'h00 : {exp_pass, exp_err, exp_mask};
                checks++;
                if (obs_res !== exp_res) begin
                    failures++;
                    $display("FAIL results h=%0d op=%0d gate=%b n=%0d got pass,err,mask=%b want %b",
                             h, op, gtt, n, obs_res, exp_res);
                end
            end
            start_drv = (n == poke_a) || (n == poke_b);
            op_drv    = 2'($urandom);
            @(negedge clk);
        end
        start_drv = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start_drv = 1'b0;
        op_drv    = 2'b00;
        gut       = TtAnd;
        sel1      = 1'b0;
        #3;
        checks++;
        if ({bus4.busy, bus4.done, bus4.a, bus4.b, bus4.pass, bus4.err_count, bus4.fail_mask,
             bus1.busy, bus1.done, bus1.a, bus1.b, bus1.pass, bus1.err_count,
             bus1.fail_mask} !== 24'h0) begin
            failures++;
            $display("FAIL reset_state got h4 ctl=%b res=%b h1 ctl=%b res=%b want all 0",
                     {bus4.busy, bus4.done, bus4.a, bus4.b},
                     {bus4.pass, bus4.err_count, bus4.fail_mask},
                     {bus1.busy, bus1.done, bus1.a, bus1.b},
                     {bus1.pass, bus1.err_count, bus1.fail_mask});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs_ctl, obs_res} !== 12'h0) begin
            failures++;
            $display("FAIL idle_after_reset got %b want 0", {obs_ctl, obs_res});
        end
    endtask

    task automatic test_and_pass();
        sel1 = 1'b0;
        run_sweep(2'b00, TtAnd, -1, -1);
    endtask

    task automatic test_mismatch_ops();
        sel1 = 1'b0;
        run_sweep(2'b01, TtAnd, -1, -1);
        run_sweep(2'b10, TtAnd, -1, -1);
        run_sweep(2'b11, TtAnd, -1, -1);
    endtask

    task automatic test_back_to_back();
        sel1 = 1'b0;
        run_sweep(2'b01, TtAnd, 3, 20);
        run_sweep(2'b00, TtAnd, 12, -1);
    endtask

    task automatic test_reset_mid_sweep();
        int h;
        sel1      = 1'b0;
        h         = 4;
        gut       = TtAnd;
        op_drv    = 2'b11;
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        repeat (2 * (h + 1)) @(negedge clk);
        checks++;
        if (obs_ctl !== 4'b1010 || obs_res !== {1'b0, 3'd2, 4'b0011}) begin
            failures++;
            $display("FAIL pre_reset_vec10 got ctl=%b res=%b want 1010 / %b",
                     obs_ctl, obs_res, {1'b0, 3'd2, 4'b0011});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({obs_ctl, obs_res} !== 12'h0) begin
            failures++;
            $display("FAIL async_reset_mid_sweep got %b want 0", {obs_ctl, obs_res});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (obs_ctl !== 4'b0000) begin
                failures++;
                $display("FAIL no_done_after_reset cycle=%0d got ctl=%b want 0000", i, obs_ctl);
            end
            @(negedge clk);
        end
        run_sweep(2'b00, TtAnd, -1, -1);
    endtask

    task automatic test_hold_one();
        sel1 = 1'b1;
        run_sweep(2'b00, TtAnd, -1, -1);
        run_sweep(2'b11, TtAnd, 2, 8);
        sel1 = 1'b0;
    endtask

    task automatic test_random();
        int len;
        int poke;
        for (int i = 0; i < 12; i++) begin
            sel1 = 1'($urandom);
            len  = sel1 ? 8 : 20;
            poke = ($urandom % 2 == 0) ? -1 : int'($urandom_range(1, len));
            run_sweep(2'($urandom), 4'($urandom), poke, -1);
        end
        sel1 = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_and_pass();
        test_mismatch_ops();
        test_back_to_back();
        test_reset_mid_sweep();
        test_hold_one();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
